// File: rtl/boreal_ledger_auditor.sv
// ---------------------------------------------------------------------------
// boreal_ledger_auditor
//
// Read-back verifier for the Phase-B ledger. On start it reads entries
// 0..n-1 and checks that each entry's 64-bit prefix (bits 255:192) equals
// the running FNV-1a-64 chain hash. It then folds the whole 256-bit entry
// into the chain, one byte per cycle with the LSB byte first. The audit
// stops at the first mismatching entry.
//
// Ports
//   clk         in   1    clock, rising edge
//   rst         in   1    asynchronous active-high reset
//   start       in   1    begin audit (sampled only when idle)
//   count       in   11   entries to audit, clamped to 1024
//   rd_req      out  1    ledger read strobe, one cycle per entry
//   rd_addr     out  10   ledger read address
//   rd_data     in   256  ledger read data, valid the cycle after rd_req
//   busy        out  1    audit in progress
//   done        out  1    one-cycle pulse at audit end
//   pass        out  1    audit result, held until the next accepted start
//   fail_addr   out  10   first mismatching address (0 on pass)
//   final_hash  out  64   chain hash after the last entry checked/folded
//   entries_ok  out  11   number of entries verified
// ---------------------------------------------------------------------------
module boreal_ledger_auditor #(
    parameter logic [63:0] SEED  = 64'hCBF2_9CE4_8422_2325,
    parameter logic [63:0] PRIME = 64'h0000_0100_0000_01B3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [10:0]  count,
    output logic         rd_req,
    output logic [9:0]   rd_addr,
    input  logic [255:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [9:0]   fail_addr,
    output logic [63:0]  final_hash,
    output logic [10:0]  entries_ok
);

    typedef enum logic [2:0] {IDLE, REQ, CHECK, HASH, DONE} state_t;

    state_t         state;
    state_t         state_next;

    logic [10:0]    n;
    logic [9:0]     addr;
    logic [63:0]    h;
    logic [255:0]   entry;
    logic [4:0]     k;
    // An empty audit spends one cycle in IDLE with this flag set, so that
    // done appears one cycle after the accepting edge instead of on it.
    logic           zero_pend;

    logic [10:0]    count_clamped;
    logic           launch;
    logic           prefix_ok;
    logic           last_byte;
    logic           last_entry;
    logic [63:0]    h_fold;

    assign count_clamped = (count > 11'd1024) ? 11'd1024 : count;
    assign launch        = (state == IDLE) && !zero_pend && start;
    assign prefix_ok     = (rd_data[255:192] == h);
    assign last_byte     = (k == 5'd31);
    assign last_entry    = ((entries_ok + 11'd1) == n);
    // Mod-2^64 product: the 64-bit assignment truncates the upper half.
    assign h_fold        = (h ^ {56'h0, entry[{k, 3'b000} +: 8]}) * PRIME;
    assign rd_addr       = addr;

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is defaulted first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        rd_req     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = zero_pend;
                if (zero_pend) begin
                    state_next = DONE;
                end else if (start && (count_clamped != 11'd0)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                rd_req     = 1'b1;
                busy       = 1'b1;
                state_next = CHECK;
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = prefix_ok ? HASH : DONE;
            end
            HASH: begin
                busy = 1'b1;
                if (last_byte) begin
                    state_next = last_entry ? DONE : REQ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n          <= '0;
            addr       <= '0;
            h          <= '0;
            k          <= '0;
            zero_pend  <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            final_hash <= '0;
            entries_ok <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (zero_pend) begin
                        zero_pend  <= 1'b0;
                        pass       <= 1'b1;
                        final_hash <= h;
                    end else if (launch) begin
                        n          <= count_clamped;
                        addr       <= '0;
                        h          <= SEED;
                        pass       <= 1'b0;
                        fail_addr  <= '0;
                        entries_ok <= '0;
                        zero_pend  <= (count_clamped == 11'd0);
                    end
                end
                CHECK: begin
                    if (!prefix_ok) begin
                        fail_addr  <= addr;
                        pass       <= 1'b0;
                        final_hash <= h;
                    end else begin
                        k <= '0;
                    end
                end
                HASH: begin
                    h <= h_fold;
                    k <= k + 5'd1;
                    if (last_byte) begin
                        entries_ok <= entries_ok + 11'd1;
                        // Wraps 1023->0 only after entry 1024, which is terminal.
                        addr       <= addr + 10'd1;
                        if (last_entry) begin
                            pass       <= 1'b1;
                            final_hash <= h_fold;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the entry buffer is pure datapath, always written in CHECK before
    // it is read in HASH, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == CHECK) begin
            entry <= rd_data;
        end
    end

endmodule

// File: tb/tb_boreal_ledger_auditor.sv
// ---------------------------------------------------------------------------
// tb_boreal_ledger_auditor
//
// Scoreboard bench: each audit pushes its expected result into sb_q before
// start; a negedge monitor pops and compares whenever done is high. A ledger
// model answers rd_req with entries whose prefixes form a valid FNV-1a-64
// chain; chain[i] holds the ledger run_hash after i writes.
// ---------------------------------------------------------------------------
module tb_boreal_ledger_auditor;

    localparam logic [63:0] SEED  = 64'hCBF2_9CE4_8422_2325;
    localparam logic [63:0] PRIME = 64'h0000_0100_0000_01B3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [10:0]  count;
    logic         rd_req;
    logic [9:0]   rd_addr;
    logic [255:0] rd_data;
    logic         busy;
    logic         done;
    logic         pass;
    logic [9:0]   fail_addr;
    logic [63:0]  final_hash;
    logic [10:0]  entries_ok;

    boreal_ledger_auditor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .count      (count),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .final_hash (final_hash),
        .entries_ok (entries_ok)
    );

    typedef struct {
        logic        pass_v;
        logic [9:0]  fail_addr_v;
        logic [63:0] hash_v;
        logic [10:0] ok_v;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [255:0] ledger_mem [1024];
    logic [63:0]  chain [1025];
    logic [9:0]   addr_q[$];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int e0         = 0;
    int done_seen  = 0;
    int rdreq_cnt  = 0;
    logic prev_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fnv_entry(input logic [63:0] hin, input logic [255:0] e);
        logic [63:0] hv;
        hv = hin;
        for (int b = 0; b < 32; b++) begin
            hv = hv ^ {56'h0, e[b*8 +: 8]};
            hv = hv * PRIME;
        end
        return hv;
    endfunction

    // Ledger read port: data for the requested address is presented mid-REQ
    // and held through the CHECK cycle.
    always @(negedge clk) begin
        if (rd_req) begin
            rd_data = ledger_mem[rd_addr];
        end
    end

    // rd_req monitor: never in consecutive cycles; count pulses and addresses.
    always @(negedge clk) begin
        if (rd_req) begin
            check("rd_req_gap", prev_req, 1'b0);
            rdreq_cnt++;
            addr_q.push_back(rd_addr);
        end
        prev_req = rd_req;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_latency", 64'(cyc - e0), 64'(mon_e.lat));
                check("pass",         pass,          mon_e.pass_v);
                check("fail_addr",    fail_addr,     mon_e.fail_addr_v);
                check("final_hash",   final_hash,    mon_e.hash_v);
                check("entries_ok",   entries_ok,    mon_e.ok_v);
                check("rd_req_count", 64'(rdreq_cnt), 64'(mon_e.reqs));
                check("busy_at_done", busy,          1'b0);
                done_seen++;
            end
        end
    end

    task automatic push_exp(input logic p, input logic [9:0] fa, input logic [63:0] hv,
                            input logic [10:0] ok, input int lat, input int reqs);
        exp_t e;
        e.pass_v      = p;
        e.fail_addr_v = fa;
        e.hash_v      = hv;
        e.ok_v        = ok;
        e.lat         = lat;
        e.reqs        = reqs;
        sb_q.push_back(e);
    endtask

    task automatic start_audit(input logic [10:0] cnt);
        @(negedge clk);
        rdreq_cnt = 0;
        addr_q.delete();
        start = 1'b1;
        count = cnt;
        @(posedge clk);
        #1;
        e0 = cyc;
        check("busy_after_start", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int target;
        target = done_seen + 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_seen >= target) break;
        end
        if (done_seen < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [191:0] payload;

        rst     = 1'b1;
        start   = 1'b0;
        count   = '0;
        rd_data = '0;

        // Build a fully written, correctly chained 1024-entry ledger.
        chain[0] = SEED;
        for (int i = 0; i < 1024; i++) begin
            payload       = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 32'(i)};
            ledger_mem[i] = {chain[i], payload};
            chain[i+1]    = fnv_entry(chain[i], ledger_mem[i]);
        end

        // Reset values.
        #1;
        check("rst_rd_req",     rd_req,     1'b0);
        check("rst_rd_addr",    rd_addr,    10'd0);
        check("rst_busy",       busy,       1'b0);
        check("rst_done",       done,       1'b0);
        check("rst_pass",       pass,       1'b0);
        check("rst_fail_addr",  fail_addr,  10'd0);
        check("rst_final_hash", final_hash, 64'd0);
        check("rst_entries_ok", entries_ok, 11'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Empty audit: done at E0+1, pass with the seed as final hash.
        push_exp(1'b1, 10'd0, SEED, 11'd0, 1, 0);
        start_audit(11'd0);
        wait_done(10, "zero");

        // Single entry.
        push_exp(1'b1, 10'd0, chain[1], 11'd1, 34, 1);
        start_audit(11'd1);
        wait_done(60, "one");

        // Four entries, entry 2 prefix bit 200 corrupted.
        ledger_mem[2][200] = ~ledger_mem[2][200];
        push_exp(1'b0, 10'd2, chain[2], 11'd2, 70, 3);
        start_audit(11'd4);
        wait_done(200, "mismatch");
        check("mismatch_addr_n", 64'(addr_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
            check("mismatch_addr", addr_q[i], 10'(i));
        end
        ledger_mem[2][200] = ~ledger_mem[2][200];

        // Second start mid-audit is ignored; only one done follows.
        push_exp(1'b1, 10'd0, chain[2], 11'd2, 68, 2);
        start_audit(11'd2);
        while (cyc < e0 + 10) @(negedge clk);
        start = 1'b1;
        count = 11'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, "restart");
        repeat (200) @(negedge clk);

        // Reset during a three-entry audit, then a clean rerun.
        start_audit(11'd3);
        while (cyc < e0 + 40) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy",       busy,       1'b1);
        check("pre_rst_entries_ok", entries_ok, 11'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rd_req",     rd_req,     1'b0);
        check("mid_rst_rd_addr",    rd_addr,    10'd0);
        check("mid_rst_busy",       busy,       1'b0);
        check("mid_rst_done",       done,       1'b0);
        check("mid_rst_pass",       pass,       1'b0);
        check("mid_rst_fail_addr",  fail_addr,  10'd0);
        check("mid_rst_final_hash", final_hash, 64'd0);
        check("mid_rst_entries_ok", entries_ok, 11'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push_exp(1'b1, 10'd0, chain[3], 11'd3, 102, 3);
        start_audit(11'd3);
        wait_done(150, "after_rst");
        check("after_rst_addr_n", 64'(addr_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
            check("after_rst_addr", addr_q[i], 10'(i));
        end

        // Full ledger with an over-range count: clamps to 1024 entries.
        push_exp(1'b1, 10'd0, chain[1024], 11'd1024, 34816, 1024);
        start_audit(11'd2047);
        wait_done(35000, "full");
        repeat (50) @(negedge clk);
        check("full_no_extra_reads", 64'(rdreq_cnt), 64'd1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boreal_ledger_auditor.md
# boreal_ledger_auditor

Read-back verifier sitting directly downstream of the Phase-B ledger's read port. On `start` it walks ledger entries 0..N-1 through `rd_req`/`rd_addr`/`rd_data` and checks that the 64-bit prefix of each entry equals the running FNV-1a-64 chain hash. It then folds the entry into the chain one byte per cycle. It reports pass/fail, the first failing address, and the final chain hash, which equals the ledger's internal `run_hash` after N writes.

## Interface
- `SEED`, 64'hCBF2_9CE4_8422_2325: initial chain hash (FNV-1a-64 offset basis).
- `PRIME`, 64'h0000_0100_0000_01B3: FNV-1a-64 multiplier.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin audit; sampled only in IDLE.
- `count`  in  11  entries to audit, sampled with `start`; values >1024 clamp to 1024.
- `rd_req`  out  1  ledger read strobe, high exactly one cycle per entry.
- `rd_addr`  out  10  ledger read address.
- `rd_data`  in  256  ledger read data, valid the cycle after `rd_req`.
- `busy`  out  1  high from the edge accepting `start` until DONE is entered.
- `done`  out  1  one-cycle pulse at audit end.
- `pass`  out  1  audit result; held until next accepted `start`.
- `fail_addr`  out  10  address of first mismatching entry; 0 on pass.
- `final_hash`  out  64  chain hash after last entry checked/folded.
- `entries_ok`  out  11  number of entries verified.

## Operation
- States: IDLE, REQ, CHECK, HASH, DONE.
- IDLE:
  - `start`=1 latches clamped `count` into `n`, clears `pass`/`fail_addr`/`entries_ok`/`addr`, and loads `h`=SEED.
  - Next state is DONE if `n`==0, else REQ.
- REQ: `rd_req`=1, `rd_addr`=`addr`. Next state is CHECK.
- CHECK:
  - Capture `rd_data` into `entry`.
  - If `rd_data[255:192]` != `h`: set `fail_addr`=`addr`, `pass`=0, `final_hash`=`h`, and go to DONE.
  - Else clear the byte counter `k`=0 and go to HASH.
- HASH (32 cycles, k=0..31):
  - `h` <= ((`h` ^ {56'h0, `entry[8k+:8]`}) * PRIME) mod 2^64.
  - Byte 0 is the LSB byte.
  - The multiply may be shift-add (2^40 + 0x1B3).
- After k=31:
  - `entries_ok`++ and `addr`++.
  - If `entries_ok`+1 == `n`: `pass`=1, `final_hash`=new `h`, go to DONE.
  - Else go to REQ.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` while not in IDLE is ignored; no queuing.
- No re-request on mismatch; the audit stops at the first bad entry.

## Timing
- Reset values: `rd_req`=0, `rd_addr`=0, `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `final_hash`=0, `entries_ok`=0. State is IDLE.
- Cycle budget: 34 cycles per entry (REQ 1, CHECK 1, HASH 32).
- Let E0 be the edge that samples `start`.
- Pass with N≥1: `done` rises at edge E0+34N. `busy` is high E0..E0+34N−1.
- N=0: `done` rises at E0+1, with `pass`=1 and `final_hash`=SEED.
- Mismatch at entry j: `done` rises at E0+34j+2. `rd_req` has pulsed j+1 times.
- `rd_req` is never asserted in consecutive cycles, and never outside REQ.
- Reset asserted mid-audit: all outputs take reset values immediately; `rd_req` drops asynchronously. `done` is not pulsed.
- `addr` wraps 1023→0 only after the 1024th entry, which is terminal. No further reads occur.

## Test plan
- Reset, then `start` with `count`=0 -> `done` at E0+1, `pass`=1, `final_hash`=CBF29CE484222325, no `rd_req`.
- Ledger model with 1 entry (event 0, prefix SEED), `count`=1 -> `done` at E0+34, `pass`=1, `entries_ok`=1, `final_hash` equals the software FNV-1a-64 of the 32 entry bytes seeded with SEED.
- 4 valid entries, entry 2 prefix bit 200 flipped -> `done` at E0+70, `pass`=0, `fail_addr`=2, `entries_ok`=2, 3 `rd_req` pulses at addresses 0,1,2.
- Fully written 1024-entry ledger, `count`=2047 -> clamped to 1024, `done` at E0+34816, `pass`=1, `final_hash` equal to the ledger's `run_hash`.
- `start` pulsed again at E0+10 of a `count`=2 audit -> ignored; single `done` at E0+68.
- `rst` asserted at E0+40 of a `count`=3 audit -> all outputs 0 immediately, no `done`. A new `start` after release audits from address 0 normally.
